// File: rtl/match_seq_ctl.sv
// Match sequencer for one PONG game: serve delay, rally, point pause, game over.
// Pauses are counted in frames (frame_tick), and every output is registered.
module match_seq_ctl #(
  parameter int SCORE_W            = 4,
  parameter int WIN_SCORE          = 7,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int POINT_PAUSE_FRAMES = 90
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               abort,
  input  logic               point_l,
  input  logic               point_r,
  output logic [2:0]         state,
  output logic               ball_en,
  output logic               serve_req,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic               winner
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SERVE_WAIT  = 3'd1,
    ST_PLAY        = 3'd2,
    ST_POINT_PAUSE = 3'd3,
    ST_GAME_OVER   = 3'd4
  } state_e;

  localparam logic [7:0]         SERVE_LAST = 8'(SERVE_DELAY_FRAMES - 1);
  localparam logic [7:0]         PAUSE_LAST = 8'(POINT_PAUSE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic               serve_dir_q, serve_dir_d;
  logic               winner_q, winner_d;
  logic               ball_en_q, ball_en_d;
  logic               serve_req_q, serve_req_d;
  logic               game_over_q, game_over_d;
  logic [SCORE_W-1:0] score_l_inc, score_r_inc;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    score_l_inc = score_l_q + SCORE_W'(1);
    score_r_inc = score_r_q + SCORE_W'(1);

    if (abort) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      score_l_d   = '0;
      score_r_d   = '0;
      serve_dir_d = 1'b0;
      winner_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_GAME_OVER: begin
          // A tick in the start cycle is not counted: the counter enters at zero.
          if (start) begin
            state_d     = ST_SERVE_WAIT;
            cnt_d       = '0;
            score_l_d   = '0;
            score_r_d   = '0;
            serve_dir_d = 1'b0;
          end
        end
        ST_SERVE_WAIT: begin
          if (frame_tick) begin
            if (cnt_q == SERVE_LAST) begin
              state_d = ST_PLAY;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        ST_PLAY: begin
          // Simultaneous points are treated as a glitch and dropped.
          if (point_l && !point_r) begin
            score_l_d   = score_l_inc;
            serve_dir_d = 1'b1;
            cnt_d       = '0;
            if (score_l_inc == WIN) begin
              state_d  = ST_GAME_OVER;
              winner_d = 1'b0;
            end else begin
              state_d = ST_POINT_PAUSE;
            end
          end else if (point_r && !point_l) begin
            score_r_d   = score_r_inc;
            serve_dir_d = 1'b0;
            cnt_d       = '0;
            if (score_r_inc == WIN) begin
              state_d  = ST_GAME_OVER;
              winner_d = 1'b1;
            end else begin
              state_d = ST_POINT_PAUSE;
            end
          end
        end
        ST_POINT_PAUSE: begin
          if (frame_tick) begin
            if (cnt_q == PAUSE_LAST) begin
              state_d = ST_SERVE_WAIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          score_l_d   = '0;
          score_r_d   = '0;
          serve_dir_d = 1'b0;
          winner_d    = 1'b0;
        end
      endcase
    end

    ball_en_d   = (state_d == ST_PLAY);
    game_over_d = (state_d == ST_GAME_OVER);
    serve_req_d = (state_q == ST_SERVE_WAIT) && (state_d == ST_PLAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      serve_dir_q <= 1'b0;
      winner_q    <= 1'b0;
      ball_en_q   <= 1'b0;
      serve_req_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      ball_en_q   <= ball_en_d;
      serve_req_q <= serve_req_d;
      game_over_q <= game_over_d;
    end
  end

  assign state     = state_q;
  assign ball_en   = ball_en_q;
  assign serve_req = serve_req_q;
  assign serve_dir = serve_dir_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_match_seq_ctl.sv
// Bench for match_seq_ctl: vector table, directed match sequences, then random
// traffic, all scored against a phase/countdown model of the match rules.
`timescale 1ns/1ps
module tb_match_seq_ctl;
  localparam int SCORE_W = 4;
  localparam int WIN_SCORE = 7;
  localparam int SD = 60;
  localparam int PP = 90;

  logic clk = 1'b0;
  logic rst, frame_tick, start, abort, point_l, point_r;
  logic [2:0] state;
  logic ball_en, serve_req, serve_dir, game_over, winner;
  logic [SCORE_W-1:0] score_l, score_r;

  match_seq_ctl #(
    .SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE),
    .SERVE_DELAY_FRAMES(SD), .POINT_PAUSE_FRAMES(PP)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .abort(abort),
    .point_l(point_l), .point_r(point_r), .state(state), .ball_en(ball_en),
    .serve_req(serve_req), .serve_dir(serve_dir), .score_l(score_l),
    .score_r(score_r), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase number (0 idle .. 4 game over) plus frames remaining in a pause.
  int m_phase, m_left, m_sl, m_sr, m_dir, m_win, m_req;

  typedef struct {
    int s, a, pl, pr, t;
    int exp_state, exp_sl, exp_sr;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_sl = 0; m_sr = 0; m_dir = 0; m_win = 0; m_req = 0;
  endtask

  task automatic model_step(input int s, input int a, input int pl, input int pr, input int t);
    m_req = 0;
    if (a != 0) begin
      m_phase = 0; m_sl = 0; m_sr = 0; m_dir = 0; m_win = 0;
    end else begin
      case (m_phase)
        0, 4: if (s != 0) begin
          m_phase = 1; m_sl = 0; m_sr = 0; m_dir = 0; m_left = SD;
        end
        1: if (t != 0) begin
          m_left--;
          if (m_left == 0) begin m_phase = 2; m_req = 1; end
        end
        2: if ((pl != 0) != (pr != 0)) begin
          if (pl != 0) begin m_sl++; m_dir = 1; end
          else begin m_sr++; m_dir = 0; end
          if (m_sl == WIN_SCORE || m_sr == WIN_SCORE) begin
            m_phase = 4; m_win = (pr != 0) ? 1 : 0;
          end else begin
            m_phase = 3; m_left = PP;
          end
        end
        3: if (t != 0) begin
          m_left--;
          if (m_left == 0) begin m_phase = 1; m_left = SD; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    check("state", int'(state), m_phase);
    check("ball_en", int'(ball_en), (m_phase == 2) ? 1 : 0);
    check("serve_req", int'(serve_req), m_req);
    check("serve_dir", int'(serve_dir), m_dir);
    check("score_l", int'(score_l), m_sl);
    check("score_r", int'(score_r), m_sr);
    check("game_over", int'(game_over), (m_phase == 4) ? 1 : 0);
    if (m_phase == 4) check("winner", int'(winner), m_win);
  endtask

  task automatic step(input int s, input int a, input int pl, input int pr, input int t);
    start = (s != 0); abort = (a != 0); point_l = (pl != 0);
    point_r = (pr != 0); frame_tick = (t != 0);
    @(posedge clk);
    model_step(s, a, pl, pr, t);
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
    end
  endtask

  task automatic point_and_reserve(input int pl, input int pr);
    step(0, 0, pl, pr, 0);
    ticks(PP);
    ticks(SD);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog time limit expired");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 0, 1, 0, 0, 0, 0, 0};  // point in IDLE ignored
    vecs[1] = '{0, 0, 0, 0, 1, 0, 0, 0};
    vecs[2] = '{1, 0, 0, 0, 1, 1, 0, 0};  // start; tick in entry cycle not counted
    vecs[3] = '{0, 0, 0, 1, 0, 1, 0, 0};  // point in SERVE_WAIT ignored
    vecs[4] = '{1, 0, 0, 0, 0, 1, 0, 0};  // start outside IDLE ignored
    vecs[5] = '{0, 1, 0, 0, 0, 0, 0, 0};
    vecs[6] = '{1, 1, 0, 0, 0, 0, 0, 0};  // abort beats start
    vecs[7] = '{1, 0, 0, 0, 0, 1, 0, 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; point_l = 1'b0; point_r = 1'b0;
    frame_tick = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_ball_en", int'(ball_en), 0);
    check("rst_serve_req", int'(serve_req), 0);
    check("rst_scores", int'(score_l) + int'(score_r), 0);
    check("rst_game_over", int'(game_over), 0);
    rst = 1'b0;
    repeat (4) step(0, 0, 0, 0, $urandom_range(0, 1));

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].s, vecs[i].a, vecs[i].pl, vecs[i].pr, vecs[i].t);
      check("vec_state", int'(state), vecs[i].exp_state);
      check("vec_score_l", int'(score_l), vecs[i].exp_sl);
      check("vec_score_r", int'(score_r), vecs[i].exp_sr);
    end

    // Serve delay boundary: 59 ticks keep SERVE_WAIT, the 60th releases.
    ticks(SD - 1);
    check("serve_wait_59", int'(state), 1);
    step(0, 0, 0, 0, 1);
    check("serve_release", int'(state), 2);
    check("serve_req_pulse", int'(serve_req), 1);
    step(0, 0, 0, 0, 0);
    check("serve_req_one_cycle", int'(serve_req), 0);

    step(0, 0, 1, 0, 0);
    check("pl_score", int'(score_l), 1);
    check("pl_dir", int'(serve_dir), 1);
    check("pl_pause", int'(state), 3);
    ticks(PP - 1);
    check("pause_89", int'(state), 3);
    ticks(1);
    check("pause_done", int'(state), 1);
    ticks(SD);
    check("reserve", int'(state), 2);

    step(0, 0, 1, 1, 0);
    check("both_state", int'(state), 2);
    check("both_scores", int'(score_l) * 16 + int'(score_r), 16);

    for (int i = 0; i < 7; i++) begin
      if (i < 6) point_and_reserve(0, 1);
      else step(0, 0, 0, 1, 0);
    end
    check("r_win_score", int'(score_r), 7);
    check("r_win_state", int'(state), 4);
    check("r_win_flag", int'(game_over), 1);
    check("r_winner", int'(winner), 1);
    check("r_win_ball_en", int'(ball_en), 0);
    step(0, 0, 1, 0, 1);
    check("go_point_ignored", int'(score_l), 1);
    step(1, 0, 0, 0, 0);
    check("restart_state", int'(state), 1);
    check("restart_scores", int'(score_l) + int'(score_r), 0);

    ticks(SD);
    point_and_reserve(1, 0); point_and_reserve(0, 1); point_and_reserve(1, 0);
    point_and_reserve(0, 1); point_and_reserve(1, 0);
    check("pre_abort_l", int'(score_l), 3);
    check("pre_abort_r", int'(score_r), 2);
    step(0, 1, 0, 0, 0);
    check("abort_play_state", int'(state), 0);
    check("abort_play_scores", int'(score_l) + int'(score_r), 0);
    check("abort_play_ball_en", int'(ball_en), 0);

    step(1, 0, 0, 0, 0);
    ticks(SD);
    for (int i = 0; i < 7; i++) begin
      if (i < 6) point_and_reserve(1, 0);
      else step(0, 0, 1, 0, 0);
    end
    check("l_winner", int'(winner), 0);
    check("l_win_state", int'(state), 4);
    step(1, 1, 0, 0, 0);
    check("abort_go_state", int'(state), 0);
    check("abort_go_scores", int'(score_l) + int'(score_r), 0);
    check("abort_go_ball_en", int'(ball_en), 0);

    for (int i = 0; i < 20000; i++) begin
      step(($urandom_range(0, 15) == 0) ? 1 : 0,
           ($urandom_range(0, 2999) == 0) ? 1 : 0,
           ($urandom_range(0, 7) == 0) ? 1 : 0,
           ($urandom_range(0, 7) == 0) ? 1 : 0,
           $urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
